// File: rtl/nbody_seq_if.sv
// ============================================================================
// Module   : nbody_seq_if
// Brief    : Software register bus between a host and the n-body sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nbody_seq_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  chipselect;
   logic                  write;
   logic                  read;
   logic [2:0]            addr;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;

   modport master (
      output chipselect, write, read, addr, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write, read, addr, writedata,
      output readdata
   );
endinterface

`default_nettype wire

// File: rtl/nbody_seq.sv
// ============================================================================
// Module   : nbody_seq
// Brief    : Time-step sequencer for an all-pairs n-body engine with CSR bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nbody_seq #(
   parameter int MAX_BODIES  = 512,
   parameter int DATA_WIDTH  = 64,
   parameter int ACC_LATENCY = 60,
   parameter int UPD_LATENCY = 20,
   localparam int BW = $clog2(MAX_BODIES)
) (
   input  logic          clk,
   input  logic          rst,
   nbody_seq_if.slave    bus,
   output logic          pair_valid,
   output logic [BW-1:0] pair_i,
   output logic [BW-1:0] pair_j,
   output logic          pair_first,
   output logic          pair_last,
   output logic          vel_wr_en,
   output logic [BW-1:0] vel_wr_addr,
   output logic          pos_rd_en,
   output logic [BW-1:0] pos_rd_addr,
   output logic          pos_wr_en,
   output logic [BW-1:0] pos_wr_addr,
   output logic          irq
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACCEL   = 3'd1,
      S_DRAIN_A = 3'd2,
      S_POS     = 3'd3,
      S_DRAIN_P = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [31:0] c_acc_last = 32'(ACC_LATENCY - 1);
   localparam logic [31:0] c_upd_last = 32'(UPD_LATENCY - 1);

   state_t        r_state, w_state_nxt;
   logic [BW:0]   r_n_bodies;
   logic [31:0]   r_steps, r_step_count, r_drain_cnt;
   logic          r_done, r_err;
   logic [BW-1:0] r_pair_i, r_pair_j, r_pos_addr;

   logic [ACC_LATENCY-1:0] r_vel_en_sr;
   logic [BW-1:0]          r_vel_addr_sr [ACC_LATENCY];
   logic [UPD_LATENCY-1:0] r_pos_en_sr;
   logic [BW-1:0]          r_pos_addr_sr [UPD_LATENCY];

   logic        w_wr, w_rd, w_ctrl_wr, w_abort, w_go, w_busy, w_go_ok, w_go_err;
   logic        w_status_rd, w_pair_end, w_wrap, w_step_end, w_last_step, w_done_set;
   logic [BW:0] w_i_ext, w_j_ext, w_n_m1, w_n_m2, w_j_inc, w_j_adv;
   logic [31:0] w_steps_eff;

   assign w_wr        = bus.chipselect & bus.write;
   assign w_rd        = bus.chipselect & bus.read;
   assign w_ctrl_wr   = w_wr && (bus.addr == 3'd0);
   assign w_abort     = w_ctrl_wr && bus.writedata[1];
   assign w_go        = w_ctrl_wr && bus.writedata[0] && !bus.writedata[1];
   assign w_busy      = (r_state == S_ACCEL) || (r_state == S_DRAIN_A) ||
                        (r_state == S_POS)   || (r_state == S_DRAIN_P);
   assign w_go_ok     = w_go && !w_busy && (r_n_bodies >= (BW+1)'(2));
   assign w_go_err    = w_go && !w_busy && (r_n_bodies <  (BW+1)'(2));
   assign w_status_rd = w_rd && (bus.addr == 3'd3);
   assign w_steps_eff = (r_steps == 32'd0) ? 32'd1 : r_steps;

   // Pair walker: j skips i, so the next candidate may be two ahead.
   assign w_i_ext    = {1'b0, r_pair_i};
   assign w_j_ext    = {1'b0, r_pair_j};
   assign w_n_m1     = r_n_bodies - (BW+1)'(1);
   assign w_n_m2     = r_n_bodies - (BW+1)'(2);
   assign w_j_inc    = w_j_ext + (BW+1)'(1);
   assign w_j_adv    = (w_j_inc == w_i_ext) ? w_j_ext + (BW+1)'(2) : w_j_inc;
   assign w_wrap     = (w_j_adv >= r_n_bodies);
   assign w_pair_end = pair_valid && (w_i_ext == w_n_m1) && (w_j_ext == w_n_m2);
   assign pair_first = pair_valid &&
                       (r_pair_j == ((r_pair_i == '0) ? BW'(1) : BW'(0)));
   assign pair_last  = pair_valid &&
                       (w_j_ext == ((w_i_ext == w_n_m1) ? w_n_m2 : w_n_m1));

   assign w_step_end  = !w_abort && (r_state == S_DRAIN_P) && (r_drain_cnt == c_upd_last);
   assign w_last_step = (r_step_count + 32'd1) == w_steps_eff;
   assign w_done_set  = (w_step_end && w_last_step) || w_go_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      pair_valid  = 1'b0;
      pos_rd_en   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: if (w_go_ok) w_state_nxt = S_ACCEL;
         S_ACCEL: begin
            pair_valid = 1'b1;
            if (w_pair_end) w_state_nxt = S_DRAIN_A;
         end
         S_DRAIN_A: if (r_drain_cnt == c_acc_last) w_state_nxt = S_POS;
         S_POS: begin
            pos_rd_en = 1'b1;
            if ({1'b0, r_pos_addr} == w_n_m1) w_state_nxt = S_DRAIN_P;
         end
         S_DRAIN_P: if (w_step_end) w_state_nxt = w_last_step ? S_DONE : S_ACCEL;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n_bodies   <= '0;
         r_steps      <= '0;
         r_step_count <= '0;
         r_drain_cnt  <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_pair_i     <= '0;
         r_pair_j     <= '0;
         r_pos_addr   <= '0;
         bus.readdata <= '0;
      end else begin
         if (w_state_nxt == S_ACCEL && r_state != S_ACCEL) begin
            r_pair_i <= '0;
            r_pair_j <= BW'(1);
         end else if (r_state == S_ACCEL && w_state_nxt == S_ACCEL) begin
            if (w_wrap) begin
               r_pair_i <= r_pair_i + BW'(1);
               r_pair_j <= '0;
            end else begin
               r_pair_j <= w_j_adv[BW-1:0];
            end
         end

         if (w_state_nxt == S_POS && r_state != S_POS)
            r_pos_addr <= '0;
         else if (r_state == S_POS && w_state_nxt == S_POS)
            r_pos_addr <= r_pos_addr + BW'(1);

         if (w_state_nxt != r_state)
            r_drain_cnt <= '0;
         else if (r_state == S_DRAIN_A || r_state == S_DRAIN_P)
            r_drain_cnt <= r_drain_cnt + 32'd1;

         if (w_go_ok)         r_step_count <= '0;
         else if (w_step_end) r_step_count <= r_step_count + 32'd1;

         if (w_abort || w_go_ok || w_status_rd) r_done <= 1'b0;
         else if (w_done_set)                   r_done <= 1'b1;

         if (w_go_ok)       r_err <= 1'b0;
         else if (w_go_err) r_err <= 1'b1;

         if (w_wr && !w_busy && bus.addr == 3'd1) begin
            if (bus.writedata > DATA_WIDTH'(MAX_BODIES))
               r_n_bodies <= (BW+1)'(MAX_BODIES);
            else
               r_n_bodies <= bus.writedata[BW:0];
         end
         if (w_wr && !w_busy && bus.addr == 3'd2)
            r_steps <= bus.writedata[31:0];

         // A flag set in the same cycle as the STATUS read is still reported.
         if (w_rd) begin
            case (bus.addr)
               3'd1:    bus.readdata <= DATA_WIDTH'(r_n_bodies);
               3'd2:    bus.readdata <= DATA_WIDTH'(r_steps);
               3'd3:    bus.readdata <= DATA_WIDTH'({r_err | w_go_err, r_done | w_done_set, w_busy});
               3'd4:    bus.readdata <= DATA_WIDTH'(r_step_count);
               default: bus.readdata <= '0;
            endcase
         end
      end
   end

   // Write-back delay lines mirror the external pipeline latencies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || w_abort) begin
         r_vel_en_sr <= '0;
         r_pos_en_sr <= '0;
         for (int k = 0; k < ACC_LATENCY; k++) r_vel_addr_sr[k] <= '0;
         for (int k = 0; k < UPD_LATENCY; k++) r_pos_addr_sr[k] <= '0;
      end else begin
         r_vel_en_sr[0]   <= pair_last;
         r_vel_addr_sr[0] <= r_pair_i;
         for (int k = 1; k < ACC_LATENCY; k++) begin
            r_vel_en_sr[k]   <= r_vel_en_sr[k-1];
            r_vel_addr_sr[k] <= r_vel_addr_sr[k-1];
         end
         r_pos_en_sr[0]   <= pos_rd_en;
         r_pos_addr_sr[0] <= r_pos_addr;
         for (int k = 1; k < UPD_LATENCY; k++) begin
            r_pos_en_sr[k]   <= r_pos_en_sr[k-1];
            r_pos_addr_sr[k] <= r_pos_addr_sr[k-1];
         end
      end
   end

   assign pair_i      = r_pair_i;
   assign pair_j      = r_pair_j;
   assign pos_rd_addr = r_pos_addr;
   assign vel_wr_en   = r_vel_en_sr[ACC_LATENCY-1];
   assign vel_wr_addr = r_vel_addr_sr[ACC_LATENCY-1];
   assign pos_wr_en   = r_pos_en_sr[UPD_LATENCY-1];
   assign pos_wr_addr = r_pos_addr_sr[UPD_LATENCY-1];
   assign irq         = r_done;

endmodule

`default_nettype wire

// File: doc/nbody_seq.md
NBODY_SEQ -- requirements
Module: nbody_seq

Interface
REQ-001 SHALL have parameter MAX_BODIES, default 512, meaning the upper bound on body count; body index width BW = clog2(MAX_BODIES).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning the bus data width.
REQ-003 SHALL have parameter ACC_LATENCY, default 60, meaning the cycles from a pair issue to its accumulated result in the external force pipeline (>=1).
REQ-004 SHALL have parameter UPD_LATENCY, default 20, meaning the cycles from a position read to its position write-back (>=1).
REQ-005 SHALL have ports clk in 1 (clock) and rst in 1 (reset; asynchronous, active-high).
REQ-006 SHALL have ports chipselect in 1, write in 1, read in 1, addr in 3, writedata in DATA_WIDTH, and readdata out DATA_WIDTH, forming the software register bus.
REQ-007 SHALL have ports pair_valid out 1, pair_i out BW, pair_j out BW, pair_first out 1 (first j of i), and pair_last out 1 (last j of i).
REQ-008 SHALL have ports vel_wr_en out 1 and vel_wr_addr out BW, driving the velocity write-back.
REQ-009 SHALL have ports pos_rd_en out 1, pos_rd_addr out BW, pos_wr_en out 1, and pos_wr_addr out BW.
REQ-010 SHALL have port irq out 1, a level interrupt equal to STATUS.done.

Function
REQ-011 Register map (word addr): 0 CTRL write-only (bit0 go, bit1 abort); 1 N_BODIES rw; 2 STEPS rw; 3 STATUS ro (bit0 busy, bit1 done, bit2 err); 4 STEP_COUNT ro; others read 0, writes ignored.
REQ-012 Bus: write accepted when chipselect&write; readdata registered, valid one cycle after chipselect&read; unselected cycles hold readdata.
REQ-013 Writes to N_BODIES/STEPS while busy SHALL be ignored; N_BODIES stored width BW+1, values >MAX_BODIES saturate to MAX_BODIES; STEPS stored 32 bits, 0 treated as 1.
REQ-014 States: IDLE, ACCEL, DRAIN_A, POS, DRAIN_P, DONE; busy=1 in ACCEL..DRAIN_P.
REQ-015 IDLE/DONE + go: if N_BODIES<2 -> set err, set done, stay non-busy; else clear done/err, STEP_COUNT<=0, enter ACCEL next cycle; go while busy ignored.
REQ-016 ACCEL: one pair per cycle, i outer 0..n-1, j inner 0..n-1, j==i skipped (no bubble); pair_first/pair_last mark first/last issued j per i; after pair (n-1,n-2) -> DRAIN_A; ACCEL lasts exactly n(n-1) cycles.
REQ-017 vel_wr_en/vel_wr_addr SHALL equal pair_last/pair_i delayed exactly ACC_LATENCY cycles (shift register, independent of state).
REQ-018 DRAIN_A lasts exactly ACC_LATENCY cycles, then POS.
REQ-019 POS: pos_rd_en=1, pos_rd_addr 0..n-1 one per cycle, exactly n cycles, then DRAIN_P; pos_wr_en/pos_wr_addr = pos_rd_en/pos_rd_addr delayed UPD_LATENCY cycles.
REQ-020 DRAIN_P lasts UPD_LATENCY cycles; at exit STEP_COUNT increments; if new STEP_COUNT==STEPS -> DONE (done=1) else ACCEL.
REQ-021 One step SHALL take exactly n(n-1)+ACC_LATENCY+n+UPD_LATENCY cycles; no pending write crosses a state boundary.
REQ-022 abort (any state): next cycle IDLE, all pair/pos strobes 0, both delay lines flushed (no further vel/pos writes), done=0, STEP_COUNT held; abort+go same write -> abort wins.
REQ-023 done clears on STATUS read or accepted go; done set and STATUS read same cycle -> read returns done=1, then clears.
REQ-024 Outside ACCEL pair_valid/pair_first/pair_last=0 and pair_i/pair_j hold last value; outside POS pos_rd_en=0.

Reset
REQ-025 rst SHALL asynchronously force: state IDLE, N_BODIES=0, STEPS=0, STEP_COUNT=0, busy/done/err=0, irq=0, readdata=0, all strobes 0, all addresses 0, delay lines cleared.
REQ-026 rst mid-run SHALL suppress all pending writes; first cycle after release is IDLE.

Verification
REQ-027 ACC_LATENCY=4, UPD_LATENCY=2, n=3, STEPS=1, go -> pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1) over 6 cycles; vel writes addr 0,1,2 at issue cycles 2,4,6 +4; pos writes 0,1,2; done/irq after exactly 15 cycles.
REQ-028 n=1, go -> err=1, done=1, no strobes ever asserted; STATUS read returns 0x6 then done clears.
REQ-029 n=4, STEPS=3 -> STEP_COUNT 1,2,3 at step ends, each step exactly 12+ACC+4+UPD cycles, done only after third.
REQ-030 abort written 2 cycles into DRAIN_A -> zero further vel_wr_en/pos_wr_en, IDLE, busy=0.
REQ-031 Write N_BODIES=7 while busy -> read returns old value; write 1000 in IDLE (MAX_BODIES=512) -> reads 512.
REQ-032 Assert rst during POS -> all outputs 0 immediately, no pos_wr_en after release, registers read 0.
